// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if: requester-side bus of the data-memory bridge.
//   master modport : drives rd_valid/rd_addr and wr_valid/wr_addr/wr_data,
//                    receives rd_ready/rd_data and wr_ready.
//   slave modport  : the bridge side of the same signals.
// valid is level-held by the requester until the matching ready pulse.
interface data_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, rd_data, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, rd_data, wr_ready
    );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: converts level-held valid / pulsed ready requests into accesses on a
// single-port synchronous SRAM with a fixed read latency. Reads and writes are serialised,
// writes win on collision, and completion is signalled with a registered one-cycle ready.
//
// Ports:
//   clk, reset   clock (rising edge) and asynchronous active-high reset
//   bus          data_mem_bridge_if.slave request bus (rd_*/wr_* valid, addr, data, ready)
//   sram_en      one-cycle access strobe
//   sram_we      1 = write, 0 = read (qualified by sram_en)
//   sram_addr    SRAM word address (low bits of the captured request address)
//   sram_wdata   write data, non-zero only while a write is in progress
//   sram_rdata   SRAM read data, SRAM_READ_LATENCY cycles after a read strobe
//   busy         high whenever the FSM is not idle
//   addr_err     sticky out-of-range flag (only with DATA_MEM_BRIDGE_BOUNDS_CHECK_EN)
//
// Build option DATA_MEM_BRIDGE_BOUNDS_CHECK_EN: addresses >= MEM_DEPTH_WORDS issue no strobe,
// reads return 0xDEADBEEF (replicated/truncated) and addr_err latches. Without it, upper
// address bits are dropped and accesses wrap modulo MEM_DEPTH_WORDS.
module data_mem_bridge #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int MEM_DEPTH_WORDS   = 4096,
    parameter int SRAM_READ_LATENCY = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    data_mem_bridge_if.slave                   bus,
    output logic                               sram_en,
    output logic                               sram_we,
    output logic [$clog2(MEM_DEPTH_WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]              sram_wdata,
    input  logic [DATA_WIDTH-1:0]              sram_rdata,
    output logic                               busy
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
    ,
    output logic                               addr_err
`endif
);
    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    function automatic logic [DATA_WIDTH-1:0] poison_word();
        logic [31:0]           pat;
        logic [DATA_WIDTH-1:0] w;
        pat = 32'hDEAD_BEEF;
        for (int i = 0; i < DATA_WIDTH; i++) w[i] = pat[i % 32];
        return w;
    endfunction

    localparam logic [DATA_WIDTH-1:0] POISON   = poison_word();
    localparam logic [1:0]            CNT_LOAD = 2'(SRAM_READ_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StWr, StRdIssue, StRdWait, StAck} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  oob_q, oob_d;
    logic                  sram_en_q, sram_en_d;
    logic                  sram_we_q, sram_we_d;
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  busy_q, busy_d;
    logic                  addr_err_q, addr_err_d;
    logic                  rd_oob, wr_oob;

`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
    // Widened compare so the check is correct for any ADDR_WIDTH vs depth.
    assign rd_oob = 64'(bus.rd_addr) >= 64'(MEM_DEPTH_WORDS);
    assign wr_oob = 64'(bus.wr_addr) >= 64'(MEM_DEPTH_WORDS);
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    // Output registers take the value of the cycle being entered, so every output is a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        oob_d        = oob_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wdata_d = '0;
        rd_ready_d   = 1'b0;
        wr_ready_d   = 1'b0;
        rd_data_d    = rd_data_q;
        addr_err_d   = addr_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.wr_valid) begin
                    state_d      = StWr;
                    addr_d       = bus.wr_addr[AW-1:0];
                    oob_d        = wr_oob;
                    sram_en_d    = !wr_oob;
                    sram_we_d    = 1'b1;
                    sram_wdata_d = bus.wr_data;
                    addr_err_d   = addr_err_q | wr_oob;
                end else if (bus.rd_valid) begin
                    state_d    = StRdIssue;
                    addr_d     = bus.rd_addr[AW-1:0];
                    oob_d      = rd_oob;
                    sram_en_d  = !rd_oob;
                    addr_err_d = addr_err_q | rd_oob;
                end
            end
            StWr: begin
                state_d    = StAck;
                wr_ready_d = 1'b1;
            end
            StRdIssue: begin
                state_d = StRdWait;
                cnt_d   = CNT_LOAD;
            end
            StRdWait: begin
                if (cnt_q == 2'd0) begin
                    state_d    = StAck;
                    rd_ready_d = 1'b1;
                    rd_data_d  = oob_q ? POISON : sram_rdata;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            oob_q        <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
            rd_ready_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            oob_q        <= oob_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
            rd_ready_q   <= rd_ready_d;
            wr_ready_q   <= wr_ready_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign sram_en      = sram_en_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign busy         = busy_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.wr_ready = wr_ready_q;
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
    assign addr_err     = addr_err_q;
`endif
endmodule

// File: tb/tb_data_mem_bridge.sv
// Testbench for data_mem_bridge: directed requests feed expected responses into queues;
// a negedge monitor pops and compares whenever the DUT pulses ready or strobes the SRAM.
module tb_data_mem_bridge;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        sram_en;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy;
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
    logic        addr_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    resp_t exp_rd[$];
    resp_t exp_wr[$];
    acc_t  exp_acc[$];

    data_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_mem_bridge #(
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .MEM_DEPTH_WORDS  (4096),
        .SRAM_READ_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .busy      (busy)
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model; non-read cycles push a marker so a mistimed capture is visible.
    logic [31:0] mem  [4096];
    logic [31:0] pipe [LAT];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        pipe[0] <= (sram_en && !sram_we) ? mem[sram_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_rdata = pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor
    logic prev_en = 1'b0;
    resp_t mr;
    acc_t  ma;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rd_ready || bus.wr_ready)
                check("ready_exclusive", {63'b0, bus.rd_ready & bus.wr_ready}, 64'd0);
            if (bus.rd_ready) begin
                if (exp_rd.size() == 0) flag("rd_ready_unexpected");
                else begin
                    mr = exp_rd.pop_front();
                    check("rd_data", 64'(bus.rd_data), 64'(mr.data));
                    check("rd_ready_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end
            if (bus.wr_ready) begin
                if (exp_wr.size() == 0) flag("wr_ready_unexpected");
                else begin
                    mr = exp_wr.pop_front();
                    check("wr_ready_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end
            if (sram_en) begin
                check("sram_en_gap", {63'b0, prev_en}, 64'd0);
                if (exp_acc.size() == 0) flag("sram_en_unexpected");
                else begin
                    ma = exp_acc.pop_front();
                    check("sram_we", {63'b0, sram_we}, {63'b0, ma.we});
                    check("sram_addr", 64'(sram_addr), 64'(ma.addr));
                    check("sram_cycle", 64'(cyc), 64'(ma.cyc));
                    if (ma.we) check("sram_wdata", 64'(sram_wdata), 64'(ma.wdata));
                end
            end else if (!busy) begin
                check("sram_wdata_idle", 64'(sram_wdata), 64'd0);
            end
            prev_en = sram_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit oob);
        int acc;
        bit seen;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        acc = cyc;
        exp_wr.push_back(resp_t'{data: 32'h0, cyc: acc + 2});
        if (!oob) exp_acc.push_back(acc_t'{we: 1'b1, addr: a[11:0], wdata: d, cyc: acc + 1});
        @(negedge clk);
        bus.wr_addr = ~a;  // must be ignored once accepted
        bus.wr_data = ~d;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.wr_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check("wr_handshake", {63'b0, seen}, 64'd1);
        bus.wr_valid = 1'b0;
    endtask

    // dly: cycles between raising valid and the expected acceptance.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int dly,
                           input bit oob);
        int acc;
        bit seen;
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        acc = cyc + dly;
        exp_rd.push_back(resp_t'{data: d, cyc: acc + 2 + LAT});
        if (!oob) exp_acc.push_back(acc_t'{we: 1'b0, addr: a[11:0], wdata: 32'h0, cyc: acc + 1});
        @(negedge clk);
        if (dly == 0) bus.rd_addr = ~a;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.rd_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check("rd_handshake", {63'b0, seen}, 64'd1);
        bus.rd_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_ready"}, {63'b0, bus.rd_ready}, 64'd0);
        check({tag, "_wr_ready"}, {63'b0, bus.wr_ready}, 64'd0);
        check({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
        check({tag, "_sram_en"}, {63'b0, sram_en}, 64'd0);
        check({tag, "_sram_we"}, {63'b0, sram_we}, 64'd0);
        check({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
        check({tag, "_sram_wdata"}, 64'(sram_wdata), 64'd0);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int acc;
        int t1;
        int t2;
        int seen_cnt;
        bit seen;
        reset        = 1'b1;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", {63'b0, busy}, 64'd0);
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
        check("addr_err_init", {63'b0, addr_err}, 64'd0);
`endif

        // Basic write then read.
        do_write(32'd5, 32'h1234_5678, 1'b0);
        do_read(32'd5, 32'h1234_5678, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("rd_data_hold", 64'(bus.rd_data), 64'h1234_5678);

        // Boundary address and background data.
        do_write(32'd0, 32'hCAFE_0000, 1'b0);
        do_write(32'd4095, 32'hFFFF_FFFF, 1'b0);
        do_read(32'd4095, 32'hFFFF_FFFF, 0, 1'b0);
        do_write(32'd1, 32'h1111_1111, 1'b0);
        do_write(32'd2, 32'h2222_2222, 1'b0);

        // Collision: write first, read accepted at the next idle cycle (3 later).
        fork
            do_write(32'd9, 32'hA5A5_A5A5, 1'b0);
            do_read(32'd9, 32'hA5A5_A5A5, 3, 1'b0);
        join

        // Held rd_valid across two reads.
        @(negedge clk);
        acc = cyc;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'd1;
        exp_rd.push_back(resp_t'{data: 32'h1111_1111, cyc: acc + 2 + LAT});
        exp_acc.push_back(acc_t'{we: 1'b0, addr: 12'd1, wdata: 32'h0, cyc: acc + 1});
        exp_rd.push_back(resp_t'{data: 32'h2222_2222, cyc: acc + 5 + 2 * LAT});
        exp_acc.push_back(acc_t'{we: 1'b0, addr: 12'd2, wdata: 32'h0, cyc: acc + 4 + LAT});
        seen = 1'b0;
        t1 = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                seen = 1'b1;
                t1 = cyc;
            end
        end
        bus.rd_addr = 32'd2;
        seen = 1'b0;
        t2 = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.rd_ready) begin
                seen = 1'b1;
                t2 = cyc;
            end
        end
        bus.rd_valid = 1'b0;
        check("b2b_gap", 64'(t2 - t1), 64'(3 + LAT));

        // Reset while waiting on read latency.
        @(negedge clk);
        acc = cyc;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 32'd5;
        exp_acc.push_back(acc_t'{we: 1'b0, addr: 12'd5, wdata: 32'h0, cyc: acc + 1});
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        bus.rd_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rd_ready) seen_cnt++;
        end
        check("midreset_no_ready", 64'(seen_cnt), 64'd0);
        check("midreset_busy", {63'b0, busy}, 64'd0);
        do_read(32'd5, 32'h1234_5678, 0, 1'b0);

        // Out-of-range address.
`ifdef DATA_MEM_BRIDGE_BOUNDS_CHECK_EN
        do_read(32'd4096, 32'hDEAD_BEEF, 0, 1'b1);
        check("addr_err_set", {63'b0, addr_err}, 64'd1);
        do_read(32'd9, 32'hA5A5_A5A5, 0, 1'b0);
        check("addr_err_sticky", {63'b0, addr_err}, 64'd1);
`else
        do_read(32'd4096, 32'hCAFE_0000, 0, 1'b0);
        do_read(32'd9, 32'hA5A5_A5A5, 0, 1'b0);
`endif

        repeat (10) @(negedge clk);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
